// File: rtl/top_pkg.sv
// Shared types and width helpers for the input buffer stage.
package top_pkg;

  localparam int default_width_c = 10;

  typedef logic [default_width_c-1:0] word_t;

  // Pointer must be at least one bit wide even for tiny depths.
  function automatic int calc_ptr_width(input int depth);
    int w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int calc_fill_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/top_inbuf_ptr.sv
// Modulo-depth pointer counter; wraps from depth_p-1 to 0 for any depth.
module top_inbuf_ptr
  import top_pkg::*;
#(
  parameter int depth_p = 4,
  parameter int ptr_w_p = calc_ptr_width(depth_p)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  input  logic               clr,
  output logic [ptr_w_p-1:0] ptr
);

  localparam logic [ptr_w_p-1:0] last_c = ptr_w_p'(depth_p - 1);

  logic [ptr_w_p-1:0] ptr_reg;
  logic [ptr_w_p-1:0] ptr_next;

  // Clear wins over increment so a flush always lands on entry 0.
  always_comb begin
    ptr_next = ptr_reg;
    if (clr) begin
      ptr_next = '0;
    end else if (inc) begin
      ptr_next = (ptr_reg == last_c) ? '0 : ptr_reg + ptr_w_p'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

  assign ptr = ptr_reg;

endmodule

// File: rtl/top_inbuf.sv
// First-word-fall-through input buffer feeding the core's data port.
module top_inbuf
  import top_pkg::*;
#(
  parameter int width_p = 10,
  parameter int depth_p = 4
) (
  input  logic                                main_clk_i,
  input  logic                                main_rst_a_i,
  input  logic                                flush_i,
  input  logic [width_p-1:0]                  in_data_i,
  input  logic                                in_valid_i,
  output logic                                in_ready_o,
  output logic [width_p-1:0]                  out_data_o,
  output logic                                out_valid_o,
  input  logic                                out_ready_i,
  output logic [calc_fill_width(depth_p)-1:0] fill_o,
  output logic                                full_o,
  output logic                                empty_o
);

  localparam int ptr_w_c  = calc_ptr_width(depth_p);
  localparam int fill_w_c = calc_fill_width(depth_p);
  localparam logic [fill_w_c-1:0] depth_fill_c = fill_w_c'(depth_p);

  logic                 push;
  logic                 pop;
  logic [ptr_w_c-1:0]   wr_ptr;
  logic [ptr_w_c-1:0]   rd_ptr;
  logic [fill_w_c-1:0]  fill_reg;
  logic [fill_w_c-1:0]  fill_next;
  logic                 full_reg;
  logic                 full_next;
  logic                 empty_reg;
  logic                 empty_next;
  logic [depth_p-1:0]   wr_en;
  logic [width_p-1:0]   mem_reg [depth_p];

  // Flush suppresses both handshakes, so the word offered alongside it is dropped.
  assign push = in_valid_i & ~full_reg & ~flush_i;
  assign pop  = ~empty_reg & out_ready_i & ~flush_i;

  top_inbuf_ptr #(
    .depth_p (depth_p),
    .ptr_w_p (ptr_w_c)
  ) u_wr_ptr (
    .clk (main_clk_i),
    .rst (main_rst_a_i),
    .inc (push),
    .clr (flush_i),
    .ptr (wr_ptr)
  );

  top_inbuf_ptr #(
    .depth_p (depth_p),
    .ptr_w_p (ptr_w_c)
  ) u_rd_ptr (
    .clk (main_clk_i),
    .rst (main_rst_a_i),
    .inc (pop),
    .clr (flush_i),
    .ptr (rd_ptr)
  );

  always_comb begin
    fill_next = fill_reg;
    if (flush_i) begin
      fill_next = '0;
    end else begin
      case ({push, pop})
        2'b10:   fill_next = fill_reg + fill_w_c'(1);
        2'b01:   fill_next = fill_reg - fill_w_c'(1);
        default: fill_next = fill_reg;
      endcase
    end
  end

  // Status flags are registered from the next fill so ready carries no comb path from inputs.
  assign full_next  = (fill_next == depth_fill_c);
  assign empty_next = (fill_next == '0);

  always_ff @(posedge main_clk_i or posedge main_rst_a_i) begin
    if (main_rst_a_i) begin
      fill_reg  <= '0;
      full_reg  <= 1'b0;
      empty_reg <= 1'b1;
    end else begin
      fill_reg  <= fill_next;
      full_reg  <= full_next;
      empty_reg <= empty_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < depth_p; gi++) begin : g_entry
      assign wr_en[gi] = push & (wr_ptr == ptr_w_c'(gi));

      always_ff @(posedge main_clk_i or posedge main_rst_a_i) begin
        if (main_rst_a_i) begin
          mem_reg[gi] <= '0;
        end else if (wr_en[gi]) begin
          mem_reg[gi] <= in_data_i;
        end
      end
    end
  endgenerate

  assign out_data_o  = mem_reg[rd_ptr];
  assign out_valid_o = ~empty_reg;
  assign in_ready_o  = ~full_reg;
  assign fill_o      = fill_reg;
  assign full_o      = full_reg;
  assign empty_o     = empty_reg;

endmodule

// File: tb/tb_top_inbuf.sv
// Scoreboard bench driving a depth-4 and a depth-3 buffer with identical stimulus.
module tb_top_inbuf;

  logic       clk;
  logic       rst;
  logic       flush;
  logic [9:0] in_data;
  logic       in_valid;
  logic       out_ready;

  logic       in_ready4, out_valid4, full4, empty4;
  logic [9:0] out_data4;
  logic [2:0] fill4;
  logic       in_ready3, out_valid3, full3, empty3;
  logic [9:0] out_data3;
  logic [1:0] fill3;

  int n_cmp;
  int n_bad;

  logic [9:0] sb [2][$];

  top_inbuf #(.width_p(10), .depth_p(4)) u_dut4 (
    .main_clk_i   (clk),
    .main_rst_a_i (rst),
    .flush_i      (flush),
    .in_data_i    (in_data),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready4),
    .out_data_o   (out_data4),
    .out_valid_o  (out_valid4),
    .out_ready_i  (out_ready),
    .fill_o       (fill4),
    .full_o       (full4),
    .empty_o      (empty4)
  );

  top_inbuf #(.width_p(10), .depth_p(3)) u_dut3 (
    .main_clk_i   (clk),
    .main_rst_a_i (rst),
    .flush_i      (flush),
    .in_data_i    (in_data),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready3),
    .out_data_o   (out_data3),
    .out_valid_o  (out_valid3),
    .out_ready_i  (out_ready),
    .fill_o       (fill3),
    .full_o       (full3),
    .empty_o      (empty3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Compare both DUTs against their models, then advance the models by this cycle's handshakes.
  task automatic tick();
    int dep, sz, f, rdy, vld, fl, em, dat;
    bit do_push, do_pop;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      dep = (k == 0) ? 4 : 3;
      if (k == 0) begin
        f = 32'(fill4); rdy = 32'(in_ready4); vld = 32'(out_valid4);
        fl = 32'(full4); em = 32'(empty4); dat = 32'(out_data4);
      end else begin
        f = 32'(fill3); rdy = 32'(in_ready3); vld = 32'(out_valid3);
        fl = 32'(full3); em = 32'(empty3); dat = 32'(out_data3);
      end
      sz = sb[k].size();
      check_eq($sformatf("d%0d_fill", dep), f, sz);
      check_eq($sformatf("d%0d_in_ready", dep), rdy, (sz < dep) ? 1 : 0);
      check_eq($sformatf("d%0d_out_valid", dep), vld, (sz > 0) ? 1 : 0);
      check_eq($sformatf("d%0d_full", dep), fl, (sz == dep) ? 1 : 0);
      check_eq($sformatf("d%0d_empty", dep), em, (sz == 0) ? 1 : 0);
      if (sz > 0) check_eq($sformatf("d%0d_out_data", dep), dat, 32'(sb[k][0]));
      do_push = in_valid && (sz < dep) && !flush;
      do_pop  = out_ready && (sz > 0) && !flush;
      if (flush) begin
        sb[k].delete();
      end else begin
        if (do_pop) void'(sb[k].pop_front());
        if (do_push) sb[k].push_back(in_data);
      end
      $display("d%0d: vin=%0b din=0x%03h rdy_o=%0b push=%0b pop=%0b flush=%0b fill=%0d",
               dep, in_valid, in_data, rdy, do_push, do_pop, flush, f);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_d4_in_ready"}, 32'(in_ready4), 1);
    check_eq({tag, "_d4_out_valid"}, 32'(out_valid4), 0);
    check_eq({tag, "_d4_out_data"}, 32'(out_data4), 0);
    check_eq({tag, "_d4_fill"}, 32'(fill4), 0);
    check_eq({tag, "_d4_full"}, 32'(full4), 0);
    check_eq({tag, "_d4_empty"}, 32'(empty4), 1);
    check_eq({tag, "_d3_out_valid"}, 32'(out_valid3), 0);
    check_eq({tag, "_d3_out_data"}, 32'(out_data3), 0);
    check_eq({tag, "_d3_fill"}, 32'(fill3), 0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1; flush = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("rst");
    rst = 1'b0;
    tick();
    tick();

    // Fill to full, then hold a fifth word.
    in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = 10'(i);
      tick();
    end
    in_data = 10'h005;
    tick();
    tick();

    // Pop one from full while offering 0x3FF; it must wait one cycle.
    in_data = 10'h3FF;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (5) tick();

    // Streaming with both sides active.
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = 10'(12'h100 + i);
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();

    // Flush together with push and pop.
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 10'h00A; tick();
    in_data = 10'h00B; tick();
    flush = 1'b1; in_data = 10'h00C; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_data = 10'h055; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    out_ready = 1'b1;
    repeat (2) tick();

    // Asynchronous reset mid-burst.
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 10'(12'h0E0 + i);
      tick();
    end
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("async_rst");
    sb[0].delete();
    sb[1].delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b1;
    in_data = 10'h077;
    tick();
    in_valid = 1'b0;
    tick();
    out_ready = 1'b1;
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/top_inbuf.md
Name: top_inbuf

Overview:
- Input buffer stage directly upstream of the top core's data_i port.
- Accepts words on a valid/ready stream and stores up to depth_p words in a first-word-fall-through FIFO.
- Presents the head word to the core on a valid/ready output.
- Absorbs bursts from the producer and reports fill level for monitoring.

Parameters:
- width_p, 10: data word width in bits; must match the core's width_p.
- depth_p, 4: number of FIFO entries; must be >= 2; any integer value is allowed, not just powers of two.

Ports:
- main_clk_i  input  1  clock.
- main_rst_a_i  input  1  async reset, active-high.
- flush_i  input  1  synchronous clear of all stored entries.
- in_data_i  input  width_p  producer data.
- in_valid_i  input  1  producer data valid.
- in_ready_o  output  1  buffer can accept a word.
- out_data_o  output  width_p  head word, feeds core data_i.
- out_valid_o  output  1  head word valid.
- out_ready_i  input  1  core consumes the head word this cycle.
- fill_o  output  $clog2(depth_p+1)  number of stored entries.
- full_o  output  1  fill_o == depth_p.
- empty_o  output  1  fill_o == 0.

Behaviour:
- Interface: one clock, main_clk_i; reset main_rst_a_i is asynchronous and active-high.
- Reset values:
  - Pointers and fill are 0, and all storage entries are cleared to 0.
  - in_ready_o=1, out_valid_o=0, out_data_o=0, fill_o=0, full_o=0, empty_o=1.
- Push: occurs when in_valid_i & in_ready_o. The word is written at wr_ptr and wr_ptr advances.
- Pop: occurs when out_valid_o & out_ready_i. rd_ptr advances.
- Pointer wrap: each pointer wraps from depth_p-1 to 0, including for non-power-of-two depths.
- Output path:
  - out_data_o = mem[rd_ptr], driven combinationally from registered storage.
  - out_valid_o = !empty_o.
  - No input-to-output bypass: latency from an accepted push to out_valid_o=1 is 1 cycle.
- Ready: in_ready_o = !full_o, registered-equivalent. When full, a simultaneous pop does not allow a push in the same cycle; in_ready_o rises the cycle after the pop.
- Fill update (fill_o, full_o and empty_o all update on the clock edge after the handshake):
  - push only: +1
  - pop only: -1
  - both: unchanged
- Simultaneous push and pop when empty: impossible, because out_valid_o=0 so no pop can occur.
- Flush:
  - flush_i has priority over push and pop in the same cycle.
  - Next cycle: pointers=0, fill_o=0, out_valid_o=0.
  - The word presented with flush_i is discarded even if in_ready_o=1.
  - Storage contents are not cleared.
- Reset mid-operation: asserting reset immediately forces the reset values asynchronously. Deassertion is synchronised externally.
- The producer holding in_valid_i while in_ready_o=0 is legal; the word is accepted later.
- Data stability: out_data_o is stable while out_valid_o=1 and out_ready_i=0.

Decomposition:
- Shared package top_pkg holds:
  - typedef for the data word, logic [width_p-1:0] default;
  - function calc_ptr_width(depth) returning max(1,$clog2(depth));
  - function calc_fill_width(depth) returning $clog2(depth+1).
- One sub-module is natural: top_inbuf_ptr, a wrap-at-depth pointer counter with inc and clr inputs. It is instantiated twice, for rd and wr.
- Storage stays inline as a register array.

Test Plan:
- Reset, then idle -> in_ready_o=1, out_valid_o=0, empty_o=1, fill_o=0, out_data_o=0.
- Push 0x001,0x002,0x003,0x004 back-to-back with out_ready_i=0, depth 4 -> full_o=1 after 4th edge, in_ready_o=0, fill_o=4, out_data_o=0x001; a 5th word held on in_valid_i is not accepted.
- From full, out_ready_i=1 for 1 cycle with in_valid_i=1 (0x3FF) -> pop 0x001, no push that cycle; next cycle in_ready_o=1, 0x3FF accepted; order 0x002,0x003,0x004,0x3FF on output.
- Streaming with in_valid_i=1 and out_ready_i=1 for 20 cycles, incrementing data -> after 1-cycle initial latency, one word per cycle; fill_o stays 1; pointer wrap is clean; depth_p=3 variant gives identical ordering.
- Fill to 2 entries, assert flush_i together with push and pop -> next cycle fill_o=0, out_valid_o=0, pushed word lost; subsequent push 0x055 appears at the output 1 cycle later.
- Assert main_rst_a_i mid-burst with fill_o=3, between clock edges -> outputs go to reset values before the next edge; after release, the first push appears with 1-cycle latency.
